mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one memory port among 2**CTRL requesters, e.g. the instruction and data caches on their miss/writeback path to main memory. Arbitration is round-robin and holds at most one transaction in flight. The winner's index is latched for the whole transaction and steers the memory response back to that requester through a `demux` instance.

## Interface
- CTRL, 1, log2 of requester count; N = 2**CTRL; legal range 1..4
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 128, line width for write data and read data
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester request; held until its req_ready pulse
- req_addr  in  [ADDR_WIDTH] x N (unpacked)  request address
- req_write  in  N  1 = write, 0 = read
- req_wdata  in  [DATA_WIDTH] x N (unpacked)  write line
- req_ready  out  N  one-cycle accept pulse, one-hot or zero
- resp_valid  out  N  one-cycle response pulse to the owner, one-hot or zero
- resp_data  out  DATA_WIDTH  response line, broadcast to all; valid only with resp_valid
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts when high together with mem_req_valid
- mem_req_addr / mem_req_write / mem_req_wdata  out  ADDR_WIDTH / 1 / DATA_WIDTH  latched request fields
- mem_resp_valid  in  1  one response per accepted request, reads and writes alike
- mem_resp_data  in  DATA_WIDTH  read data; don't-care for writes
- busy  out  1  high whenever state is not IDLE
- grant_idx  out  CTRL  latched winner; holds its last value while IDLE

## Operation
- FSM with three states: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid is high:
  - Pick the winner: first set bit scanning upward from rr_ptr, modulo N.
  - Pulse req_ready[winner] combinationally in this cycle.
  - Latch winner, addr, write and wdata; go to ISSUE.
- ISSUE:
  - mem_req_valid = 1, driven only from the latched registers.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, register mem_resp_data into resp_data and the demux output into resp_valid.
  - Set rr_ptr = grant_idx + 1 (wraps N-1 -> 0), then return to IDLE.
- mem_resp_valid in IDLE or ISSUE, including the accept cycle itself, is ignored; memory must respond at least one cycle after accept.
- req_valid on non-winners is ignored while busy. A requester must not raise a new request before it receives its own response.
- Requests are never dropped or reordered; there is no error path.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_idx 0.
- All outputs are 0 during and after reset: req_ready, resp_valid, resp_data, mem_req_*, busy.
- req_ready is a Mealy output in the IDLE cycle. Every other output is a registered state/data output.
- Cycle A: IDLE accept. Cycle A+1: mem_req_valid high.
- mem_resp_valid in cycle R (R > accept cycle) gives resp_valid in cycle R+1; the FSM is IDLE in R+1.
- A new grant can occur in R+1 itself. Minimum per transaction: 3 cycles + memory latency.
- Reset asserted mid-transaction: the in-flight transaction is abandoned, no resp_valid is produced, and everything returns to reset values next cycle.
- Simultaneous requests from all N: each is served exactly once in N consecutive transactions.

## Configuration
- MEM_ARB_RR_EN defined: round-robin as above.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. rr_ptr is not instantiated and the scan always starts at 0.
- All other behaviour and timing are identical in both builds.

## Structure
- brisc_pkg holds typedef enum logic [1:0] mem_arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
- brisc_pkg holds localparam MEM_ARB_MAX_CTRL = 4 for elaboration checks.
- One sub-module: existing `demux` with CTRL = CTRL, DATA_WIDTH = 1. Its inp is mem_resp_valid && state==ARB_WAIT and its ctrl is grant_idx; its out feeds the resp_valid register.
- The winner scan is an in-module function; it is not a separate module.

## Test plan
- Single read, CTRL=1: req_valid=2'b10, addr 0x100; memory ready immediately and responds 3 cycles later with data 0xAB -> req_ready=2'b10 in the accept cycle; mem_req_addr=0x100 with write=0; resp_valid=2'b10 with resp_data=0xAB exactly one cycle after mem_resp_valid; busy then low.
- Contention, CTRL=2, RR build: all four requesters held valid -> grants 0,1,2,3,0 in order and rr_ptr wraps 3->0. Fixed-priority build -> requester 0 is granted every time it re-requests.
- Back-pressure: mem_req_ready held low for 5 cycles -> mem_req_valid and fields stay stable; no second req_ready pulse.
- Write: req_write=1, wdata 0xDEAD -> mem_req_wdata=0xDEAD and mem_req_write=1; ack produces a resp_valid pulse to the writer.
- Spurious mem_resp_valid in IDLE and in the accept cycle -> no resp_valid pulse.
- Reset during WAIT -> all outputs 0 next cycle; the later mem_resp_valid is ignored; the next request is granted from index 0.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types and limits for the brisc memory-side blocks.
// Holds the memory arbiter FSM encoding and its elaboration bounds.
package brisc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } mem_arb_state_e;

    localparam int MEM_ARB_MAX_CTRL = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory buses of mem_arbiter bundled into one interface.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
    parameter int CTRL       = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    localparam int N = 2 ** CTRL;

    // Handshakes: a request transfers in the cycle where valid and ready are
    // both high; valid is held unchanged until then. Responses are one-cycle
    // pulses with no ready, and data is meaningful only alongside the pulse.
    logic [N-1:0]            req_valid;
    logic [ADDR_WIDTH-1:0]   req_addr  [N];
    logic [N-1:0]            req_write;
    logic [DATA_WIDTH-1:0]   req_wdata [N];
    logic [N-1:0]            req_ready;
    logic [N-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]   resp_data;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic                    mem_req_write;
    logic [DATA_WIDTH-1:0]   mem_req_wdata;
    logic                    mem_resp_valid;
    logic [DATA_WIDTH-1:0]   mem_resp_data;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data,
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
    );

endinterface

// File: rtl/mem_arbiter_demux.sv
// Generic 1-to-2**CTRL demultiplexer: the selected output lane carries inp,
// all other lanes are zero.
module demux #(
    parameter int CTRL       = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic [DATA_WIDTH-1:0]            inp,
    input  logic [CTRL-1:0]                  ctrl,
    output logic [(2**CTRL)*DATA_WIDTH-1:0]  out
);

    always_comb begin
        out = '0;
        out[int'(ctrl)*DATA_WIDTH +: DATA_WIDTH] = inp;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among 2**CTRL requesters, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin; otherwise lowest index wins.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int CTRL       = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic            clk,
    input  logic            reset,
    mem_arbiter_if.master   bus,
    output logic            busy,
    output logic [CTRL-1:0] grant_idx,
    output mem_arb_state_e  state_dbg
);

    localparam int N = 2 ** CTRL;

    generate
        if (CTRL < 1 || CTRL > MEM_ARB_MAX_CTRL) begin : g_bad_ctrl
            $error("mem_arbiter: CTRL out of range");
        end
    endgenerate

    mem_arb_state_e         state;
    logic [CTRL-1:0]        grant_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   write_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [N-1:0]           resp_valid_q;
    logic [DATA_WIDTH-1:0]  resp_data_q;
    logic [CTRL-1:0]        scan_base;
    logic [CTRL-1:0]        winner;
    logic                   grant_now;
    logic                   resp_fire;
    logic [N-1:0]           req_ready_c;
    logic [N-1:0]           demux_out;

`ifdef MEM_ARB_RR_EN
    logic [CTRL-1:0]        rr_ptr;
    assign scan_base = rr_ptr;
`else
    assign scan_base = '0;
`endif

    // First requester at or above base, wrapping modulo N.
    function automatic logic [CTRL-1:0] pick_winner(input logic [N-1:0] reqs,
                                                    input logic [CTRL-1:0] base);
        logic [CTRL-1:0] idx;
        logic            found;
        pick_winner = base;
        found       = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = base + CTRL'(i);
            if (!found && reqs[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign winner    = pick_winner(bus.req_valid, scan_base);
    assign grant_now = !reset && (state == ARB_IDLE) && (|bus.req_valid);
    assign resp_fire = bus.mem_resp_valid && (state == ARB_WAIT);

    always_comb begin
        req_ready_c = '0;
        if (grant_now) req_ready_c[winner] = 1'b1;
    end

    demux #(
        .CTRL       (CTRL),
        .DATA_WIDTH (1)
    ) u_resp_demux (
        .inp  (resp_fire),
        .ctrl (grant_q),
        .out  (demux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            grant_q      <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr       <= '0;
`endif
        end else begin
            resp_valid_q <= demux_out;
            if (resp_fire) resp_data_q <= bus.mem_resp_data;
            case (state)
                ARB_IDLE: begin
                    if (|bus.req_valid) begin
                        grant_q <= winner;
                        addr_q  <= bus.req_addr[winner];
                        write_q <= bus.req_write[winner];
                        wdata_q <= bus.req_wdata[winner];
                        state   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.mem_req_ready) state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    // Pointer moves only on completion so an abandoned
                    // transaction never skews fairness.
                    if (bus.mem_resp_valid) begin
`ifdef MEM_ARB_RR_EN
                        rr_ptr <= grant_q + 1'b1;
`endif
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = (state == ARB_ISSUE);
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_write = write_q;
    assign bus.mem_req_wdata = wdata_q;
    assign busy              = (state != ARB_IDLE);
    assign grant_idx         = grant_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with 4 requesters.
// Predicts grants, memory requests and responses from the arbitration rules.
module tb_mem_arbiter;
    import brisc_pkg::*;

    localparam int CTRL = 2;
    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    typedef struct packed {
        logic [CTRL-1:0] idx;
        logic            write;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   rdata;
    } txn_t;
    localparam int TW = $bits(txn_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            busy;
    logic [CTRL-1:0] grant_idx;
    mem_arb_state_e  state_dbg;

    mem_arbiter_if #(.CTRL(CTRL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.CTRL(CTRL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx),
        .state_dbg (state_dbg)
    );

    // ---------------- shared bench state ----------------
    int tests = 0;
    int fails = 0;

    logic [N-1:0]  rv, awaiting, rq_write, rereq;
    logic [AW-1:0] rq_addr  [N];
    logic [DW-1:0] rq_wdata [N];
    int            ready_pct, lat_min, lat_max, cnt;
    bit            spur_en, rand_req, outstanding, mem_legit;
    logic [AW-1:0] acc_addr;
    logic          acc_write;
    logic [DW-1:0] acc_wdata;
    logic [DW-1:0] mem_store [logic [AW-1:0]];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            grant_log[$];
    logic [TW-1:0] exp_q[$];

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r, input int base);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (base + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bus();
        bus.req_valid = rv;
        bus.req_write = rq_write;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i]  = rq_addr[i];
            bus.req_wdata[i] = rq_wdata[i];
        end
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        rq_addr[i]  = a;
        rq_write[i] = w;
        rq_wdata[i] = d;
        rv[i]       = 1'b1;
        drive_bus();
    endtask

    // One clock: sample at the falling edge, update inputs just after the rising edge.
    task automatic tick();
        logic [N-1:0] acc_req, got_resp;
        logic         acc_mem;
        @(negedge clk);
        acc_req  = bus.req_ready;
        got_resp = bus.resp_valid;
        acc_mem  = bus.mem_req_valid && bus.mem_req_ready;
        if (acc_mem) begin
            acc_addr  = bus.mem_req_addr;
            acc_write = bus.mem_req_write;
            acc_wdata = bus.mem_req_wdata;
        end
        @(posedge clk);
        #1;
        rv       = rv & ~acc_req;
        awaiting = (awaiting | acc_req) & ~got_resp;
        if (acc_mem) begin
            if (acc_write) mem_store[acc_addr] = acc_wdata;
            outstanding = 1'b1;
            cnt = $urandom_range(lat_max, lat_min);
        end
        bus.mem_req_ready  = ($urandom_range(0, 99) < ready_pct);
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = $urandom;
        mem_legit          = 1'b0;
        if (outstanding) begin
            if (cnt == 0) begin
                bus.mem_resp_valid = 1'b1;
                mem_legit          = 1'b1;
                outstanding        = 1'b0;
                if (!acc_write)
                    bus.mem_resp_data = mem_store.exists(acc_addr) ? mem_store[acc_addr] : mem_init(acc_addr);
            end else begin
                cnt--;
            end
        end else if (spur_en && ((bus.mem_req_valid && bus.mem_req_ready) || $urandom_range(0, 2) == 0)) begin
            bus.mem_resp_valid = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (!rv[i] && !awaiting[i] && !reset) begin
                if (rereq[i])
                    raise(i, 32'h200 + 32'(i * 4), 1'b0, $urandom);
                else if (rand_req && $urandom_range(0, 99) < 30)
                    raise(i, 32'h100 + 32'($urandom_range(0, 7) * 4), ($urandom_range(0, 3) == 0), $urandom);
            end
        end
        drive_bus();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while ((rv != 0 || awaiting != 0 || outstanding) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail_timeout(name);
    endtask

    task automatic do_reset(input int k);
        int saved;
        saved       = ready_pct;
        ready_pct   = 0;
        reset       = 1'b1;
        rv          = '0;
        awaiting    = '0;
        outstanding = 1'b0;
        drive_bus();
        repeat (k) tick();
        reset       = 1'b0;
        outstanding = 1'b0;
        awaiting    = '0;
        ready_pct   = saved;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int             phase, model_ptr, w;
        bit             post_rst, legit_prev;
        txn_t           cur, prev;
        logic [N-1:0]   exp_rdy, exp_resp;
        phase = 0; model_ptr = 0; post_rst = 1'b0; legit_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase      = 0;
                model_ptr  = 0;
                legit_prev = 1'b0;
                post_rst   = 1'b1;
                exp_q.delete();
                chk("req_ready_in_reset", bus.req_ready, '0);
            end else begin
                if (post_rst) begin
                    chk("rst_resp_data", bus.resp_data, '0);
                    chk("rst_mem_req_addr", bus.mem_req_addr, '0);
                    chk("rst_mem_req_write", bus.mem_req_write, 1'b0);
                    chk("rst_mem_req_wdata", bus.mem_req_wdata, '0);
                    chk("rst_grant_idx", grant_idx, '0);
                    post_rst = 1'b0;
                end
                exp_rdy = '0;
                w = -1;
                if (phase == 0 && rv != 0) begin
                    w = model_pick(rv, model_ptr);
                    exp_rdy[w] = 1'b1;
                end
                chk("req_ready", bus.req_ready, exp_rdy);
                chk("busy", busy, phase != 0);
                chk("mem_req_valid", bus.mem_req_valid, phase == 1);
                if (phase == 1 && exp_q.size() > 0) begin
                    cur = txn_t'(exp_q[0]);
                    chk("mem_req_addr", bus.mem_req_addr, cur.addr);
                    chk("mem_req_write", bus.mem_req_write, cur.write);
                    chk("mem_req_wdata", bus.mem_req_wdata, cur.wdata);
                    chk("grant_idx", grant_idx, cur.idx);
                end
                exp_resp = '0;
                if (legit_prev) exp_resp[prev.idx] = 1'b1;
                chk("resp_valid", bus.resp_valid, exp_resp);
                if (legit_prev && !prev.write) chk("resp_data", bus.resp_data, prev.rdata);
                legit_prev = 1'b0;

                case (phase)
                    0: if (w >= 0) begin
                        cur.idx   = CTRL'(w);
                        cur.addr  = rq_addr[w];
                        cur.write = rq_write[w];
                        cur.wdata = rq_wdata[w];
                        if (rq_write[w]) begin
                            mem_model[rq_addr[w]] = rq_wdata[w];
                            cur.rdata = '0;
                        end else begin
                            cur.rdata = mem_model.exists(rq_addr[w]) ? mem_model[rq_addr[w]] : mem_init(rq_addr[w]);
                        end
                        exp_q.push_back(TW'(cur));
                        grant_log.push_back(w);
`ifdef MEM_ARB_RR_EN
                        model_ptr = (w + 1) % N;
`endif
                        phase = 1;
                    end
                    1: if (bus.mem_req_ready) phase = 2;
                    2: if (bus.mem_resp_valid && mem_legit && exp_q.size() > 0) begin
                        prev       = txn_t'(exp_q.pop_front());
                        legit_prev = 1'b1;
                        phase      = 0;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1;
        rv = '0; awaiting = '0; rq_write = '0; rereq = '0;
        for (int i = 0; i < N; i++) begin
            rq_addr[i]  = '0;
            rq_wdata[i] = '0;
        end
        ready_pct = 100; lat_min = 0; lat_max = 3; cnt = 0;
        spur_en = 1'b0; rand_req = 1'b0; outstanding = 1'b0; mem_legit = 1'b0;
        acc_addr = '0; acc_write = 1'b0; acc_wdata = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        mem_store[32'h100] = 32'hAB;
        mem_model[32'h100] = 32'hAB;
        drive_bus();
        repeat (3) tick();
        reset = 1'b0;

        // single read from requester 1, response 3 cycles after accept
        lat_min = 2; lat_max = 2;
        raise(1, 32'h100, 1'b0, 32'h1234);
        wait_done(50, "single_read");
        repeat (2) tick();

        // contention from a fresh reset
        do_reset(1);
        grant_log.delete();
        lat_min = 0; lat_max = 2;
        rereq = '1;
        n = 0;
        while (grant_log.size() < N + 1 && n < 300) begin
            tick();
            n++;
        end
        rereq = '0;
        if (grant_log.size() < N + 1) fail_timeout("contention");
        else begin
`ifdef MEM_ARB_RR_EN
            for (int k = 0; k <= N; k++) chk("rr_order", grant_log[k], k % N);
`else
            chk("fixed_first", grant_log[0], 0);
            chk("fixed_rerequest", grant_log[2], 0);
            chk("fixed_rerequest2", grant_log[4], 0);
`endif
        end
        wait_done(100, "contention_drain");

        // back-pressure on a write, with a competing request held meanwhile
        ready_pct = 0;
        raise(2, 32'h104, 1'b1, 32'hDEAD);
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) fail_timeout("backpressure_issue");
        raise(3, 32'h108, 1'b0, 32'h0);
        repeat (5) tick();
        ready_pct = 100;
        wait_done(60, "backpressure");
        raise(0, 32'h104, 1'b0, 32'h0);
        wait_done(40, "readback");

        // spurious memory responses in idle and in the accept cycle
        spur_en = 1'b1;
        repeat (4) tick();
        raise(1, 32'h10C, 1'b0, 32'h0);
        wait_done(40, "spurious");
        repeat (3) tick();
        spur_en = 1'b0;

        // reset while waiting on memory
        lat_min = 6; lat_max = 6;
        raise(0, 32'h108, 1'b0, 32'h0);
        n = 0;
        while (!(outstanding && cnt >= 3) && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) fail_timeout("reach_wait");
        do_reset(1);
        spur_en = 1'b1;
        repeat (3) tick();
        spur_en = 1'b0;
        lat_min = 0; lat_max = 3;
        raise(2, 32'h110, 1'b0, 32'h0);
        raise(3, 32'h114, 1'b0, 32'h0);
        wait_done(60, "after_reset");

        // random traffic
        lat_min = 0; lat_max = 4; ready_pct = 60;
        spur_en = 1'b1; rand_req = 1'b1;
        repeat (1500) tick();
        rand_req = 1'b0; spur_en = 1'b0;
        wait_done(300, "random_drain");
        repeat (3) tick();
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d expected responses never arrived", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
